instruction_encoder: RTL and testbench

- Inverse of the XMakina instruction decoder. Accepts field-level encode requests over a valid/ready handshake and packs each one into a 16-bit XMakina instruction word.
- Writes the words sequentially into instruction memory, starting at a loadable byte base address.
- Used by the self-test/boot loader path to build programs in memory. Range-checks every field and rejects requests that cannot be encoded.

---
 rtl/xmakina_pkg.sv | 51 +++++
 rtl/instruction_packer.sv | 73 +++++++
 rtl/instruction_encoder.sv | 121 ++++++++++++
 tb/tb_instruction_encoder.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmakina_pkg.sv
// Shared XMakina definitions: instruction classes, function codes, error codes
// and the offset limits used when encoding instructions.
package xmakina_pkg;

   typedef enum logic [3:0] {
      CLS_BL    = 4'd0,
      CLS_BRC   = 4'd1,
      CLS_ALU   = 4'd2,
      CLS_SHIFT = 4'd3,
      CLS_SWAP  = 4'd4,
      CLS_LD    = 4'd5,
      CLS_ST    = 4'd6,
      CLS_SVC   = 4'd7,
      CLS_CEX   = 4'd8,
      CLS_MOVI  = 4'd9,
      CLS_LDR   = 4'd10,
      CLS_STR   = 4'd11
   } inst_class_t;

   localparam logic [3:0] ALU_FUNC_SWAP = 4'b1100;
   localparam logic [3:0] ALU_FUNC_SRA  = 4'b1101;
   localparam logic [3:0] ALU_FUNC_RRC  = 4'b1110;

   typedef enum logic [1:0] {
      MOV_L  = 2'b00,
      MOV_LZ = 2'b01,
      MOV_LS = 2'b10,
      MOV_H  = 2'b11
   } mov_kind_t;

   typedef enum logic [1:0] {
      ERR_ILLEGAL  = 2'd0,
      ERR_RANGE    = 2'd1,
      ERR_MISALIGN = 2'd2
   } err_code_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DRAIN,
      ST_DONE
   } enc_state_t;

   localparam logic signed [15:0] BL_OFF_MIN  = -16'sd8192;
   localparam logic signed [15:0] BL_OFF_MAX  = 16'sd8190;
   localparam logic signed [15:0] BRC_OFF_MIN = -16'sd1024;
   localparam logic signed [15:0] BRC_OFF_MAX = 16'sd1022;
   localparam logic signed [15:0] REL_OFF_MIN = -16'sd64;
   localparam logic signed [15:0] REL_OFF_MAX = 16'sd63;

endpackage

// File: rtl/instruction_packer.sv
// Combinational field packer: turns one encode request into an XMakina word
// and reports whether it is encodable, with the highest-priority error code.
module instruction_packer
   import xmakina_pkg::*;
(
   input  logic [3:0]  cls,
   input  logic [3:0]  func,
   input  logic        rc,
   input  logic        byte_op,
   input  logic [2:0]  src,
   input  logic [2:0]  dst,
   input  logic [2:0]  cond,
   input  logic [15:0] offset,
   input  logic [2:0]  addr_mode,
   input  logic [1:0]  mov_kind,
   input  logic [7:0]  imm,
   input  logic [9:0]  payload,
   output logic [15:0] word,
   output logic        legal,
   output err_code_t   code
);

   logic signed [15:0] off;
   logic               illegal;
   logic               misaligned;
   logic               out_of_range;

   assign off = offset;

   always_comb begin
      word         = '0;
      illegal      = 1'b0;
      misaligned   = 1'b0;
      out_of_range = 1'b0;
      unique case (inst_class_t'(cls))
         CLS_BL: begin
            word         = {3'b000, offset[13:1]};
            misaligned   = offset[0];
            out_of_range = (off < BL_OFF_MIN) || (off > BL_OFF_MAX);
         end
         CLS_BRC: begin
            word         = {3'b001, cond, offset[10:1]};
            misaligned   = offset[0];
            out_of_range = (off < BRC_OFF_MIN) || (off > BRC_OFF_MAX);
         end
         CLS_ALU: begin
            word    = {4'b0100, func, rc, byte_op, src, dst};
            illegal = (func == ALU_FUNC_SWAP) || (func == ALU_FUNC_SRA);
         end
         CLS_SHIFT:
            word = {4'b0100, (func[0] ? ALU_FUNC_RRC : ALU_FUNC_SRA), rc, byte_op, src, dst};
         CLS_SWAP:
            word = {4'b0100, ALU_FUNC_SWAP, rc, byte_op, src, dst};
         CLS_LD, CLS_ST:
            word = {4'b0101, 1'b0, (cls == CLS_ST), addr_mode, byte_op, src, dst};
         CLS_SVC, CLS_CEX:
            word = {4'b0101, 1'b1, (cls == CLS_CEX), payload};
         CLS_MOVI:
            word = {3'b011, mov_kind, imm, dst};
         CLS_LDR, CLS_STR: begin
            word         = {1'b1, (cls == CLS_STR), offset[6:0], byte_op, src, dst};
            out_of_range = (off < REL_OFF_MIN) || (off > REL_OFF_MAX);
         end
         default:
            illegal = 1'b1;
      endcase
   end

   assign legal = !(illegal || misaligned || out_of_range);
   assign code  = illegal    ? ERR_ILLEGAL  :
                  misaligned ? ERR_MISALIGN : ERR_RANGE;

endmodule

// File: rtl/instruction_encoder.sv
// Session-based instruction encoder: accepts field requests, packs them and
// streams the words into instruction memory from a loadable base address.
module instruction_encoder
   import xmakina_pkg::*;
#(
   parameter int unsigned WORD = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [WORD-1:0] base_addr,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_class,
   input  logic [3:0]      req_func,
   input  logic            req_rc,
   input  logic            req_byte,
   input  logic [2:0]      req_src,
   input  logic [2:0]      req_dst,
   input  logic [2:0]      req_cond,
   input  logic [WORD-1:0] req_offset,
   input  logic [2:0]      req_addr_mode,
   input  logic [1:0]      req_mov_kind,
   input  logic [7:0]      req_imm,
   input  logic [9:0]      req_payload,
   input  logic            req_last,
   output logic            mem_wr_en,
   output logic [WORD-1:0] mem_addr,
   output logic [WORD-1:0] mem_wdata,
   input  logic            mem_ready,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [1:0]      err_code,
   output logic [WORD-1:0] word_count
);

   enc_state_t  state;
   enc_state_t  state_next;
   logic        accept;
   logic        wr_done;
   logic        start_ok;
   logic [15:0] pk_word;
   logic        pk_legal;
   err_code_t   pk_code;

   instruction_packer u_packer (
      .cls       (req_class),
      .func      (req_func),
      .rc        (req_rc),
      .byte_op   (req_byte),
      .src       (req_src),
      .dst       (req_dst),
      .cond      (req_cond),
      .offset    (req_offset),
      .addr_mode (req_addr_mode),
      .mov_kind  (req_mov_kind),
      .imm       (req_imm),
      .payload   (req_payload),
      .word      (pk_word),
      .legal     (pk_legal),
      .code      (pk_code)
   );

   assign wr_done   = mem_wr_en && mem_ready;
   assign req_ready = (state == ST_ACTIVE) && (!mem_wr_en || mem_ready);
   assign accept    = req_valid && req_ready;
   assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign busy      = (state == ST_ACTIVE) || (state == ST_DRAIN);
   assign done      = (state == ST_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE, ST_DONE: if (start) state_next = ST_ACTIVE;
         ST_ACTIVE:        if (accept && req_last) state_next = ST_DRAIN;
         ST_DRAIN:         if (!mem_wr_en || mem_ready) state_next = ST_DONE;
         default:          state_next = ST_IDLE;
      endcase
   end

   // mem_addr doubles as the write pointer; a completing write and a newly
   // loaded word in the same cycle give one word per clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wr_en  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         word_count <= '0;
         err        <= 1'b0;
         err_code   <= '0;
      end else if (start_ok) begin
         mem_wr_en  <= 1'b0;
         mem_addr   <= base_addr;
         word_count <= '0;
         err        <= 1'b0;
         err_code   <= '0;
      end else begin
         if (wr_done) begin
            mem_addr   <= mem_addr + WORD'(2);
            word_count <= word_count + WORD'(1);
         end
         if (accept && pk_legal) begin
            mem_wdata <= pk_word;
            mem_wr_en <= 1'b1;
         end else if (wr_done) begin
            mem_wr_en <= 1'b0;
         end
         if (accept && !pk_legal) begin
            err <= 1'b1;
            if (!err) err_code <= pk_code;
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: written words are predicted
// into a scoreboard and compared as the memory interface completes them.
module tb_instruction_encoder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_class;
   logic [3:0]  req_func;
   logic        req_rc;
   logic        req_byte;
   logic [2:0]  req_src;
   logic [2:0]  req_dst;
   logic [2:0]  req_cond;
   logic [15:0] req_offset;
   logic [2:0]  req_addr_mode;
   logic [1:0]  req_mov_kind;
   logic [7:0]  req_imm;
   logic [9:0]  req_payload;
   logic        req_last;
   logic        mem_wr_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [15:0] word_count;

   instruction_encoder #(.WORD(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_class     (req_class),
      .req_func      (req_func),
      .req_rc        (req_rc),
      .req_byte      (req_byte),
      .req_src       (req_src),
      .req_dst       (req_dst),
      .req_cond      (req_cond),
      .req_offset    (req_offset),
      .req_addr_mode (req_addr_mode),
      .req_mov_kind  (req_mov_kind),
      .req_imm       (req_imm),
      .req_payload   (req_payload),
      .req_last      (req_last),
      .mem_wr_en     (mem_wr_en),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ready     (mem_ready),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_code      (err_code),
      .word_count    (word_count)
   );

   typedef struct {
      logic [3:0]  cls;
      logic [3:0]  func;
      logic        rc;
      logic        byt;
      logic [2:0]  src;
      logic [2:0]  dst;
      logic [2:0]  cond;
      logic [15:0] offset;
      logic [2:0]  addr_mode;
      logic [1:0]  kind;
      logic [7:0]  imm;
      logic [9:0]  payload;
      logic        last;
   } req_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          total;
   int          bad;
   logic [15:0] exp_ptr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // write monitor: every completed write must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && mem_wr_en && mem_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL write_unexpected: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({mem_addr, mem_wdata} !== {e.addr, e.data}) begin
               bad++;
               $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   function automatic req_t blank(input logic [3:0] c);
      req_t r;
      r = '{default: '0};
      r.cls = c;
      return r;
   endfunction

   task automatic send(input req_t r, input bit legal, input logic [15:0] word);
      bit ok;
      req_class     = r.cls;
      req_func      = r.func;
      req_rc        = r.rc;
      req_byte      = r.byt;
      req_src       = r.src;
      req_dst       = r.dst;
      req_cond      = r.cond;
      req_offset    = r.offset;
      req_addr_mode = r.addr_mode;
      req_mov_kind  = r.kind;
      req_imm       = r.imm;
      req_payload   = r.payload;
      req_last      = r.last;
      req_valid     = 1'b1;
      if (legal) begin
         sb.push_back({exp_ptr, word});
         exp_ptr += 16'd2;
      end
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL handshake: got req_ready=0 for 50 cycles, expected acceptance");
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_last  = 1'b0;
   endtask

   task automatic start_session(input logic [15:0] base);
      base_addr = base;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      exp_ptr = base;
      total++;
      if ({busy, done, err, mem_wr_en, word_count, mem_addr} !== {4'b1000, 16'h0000, base}) begin
         bad++;
         $display("FAIL start_state: got busy=%b done=%b err=%b wr=%b count=%h addr=%h, expected 1 0 0 0 0000 %h",
                  busy, done, err, mem_wr_en, word_count, mem_addr, base);
      end
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      total++;
      if (!ok || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_done: got done=%b busy=%b, expected done=1 busy=0", tag, done, busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_end(input string tag, input logic [15:0] count,
                            input logic e, input logic [1:0] code);
      total++;
      if ({word_count, err, err_code} !== {count, e, code}) begin
         bad++;
         $display("FAIL %s_end: got count=%h err=%b code=%0d, expected count=%h err=%b code=%0d",
                  tag, word_count, err, err_code, count, e, code);
      end
   endtask

   task automatic check_out(input string tag, input logic [15:0] addr, input logic [15:0] data);
      total++;
      if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, addr, data}) begin
         bad++;
         $display("FAIL %s_latency: got wr=%b addr=%h data=%h, expected 1 %h %h",
                  tag, mem_wr_en, mem_addr, mem_wdata, addr, data);
      end
   endtask

   task automatic check_all_zero(input string tag);
      total++;
      if ({req_ready, mem_wr_en, mem_addr, mem_wdata, busy, done, err, err_code, word_count} !== '0) begin
         bad++;
         $display("FAIL %s_zero: got rdy=%b wr=%b addr=%h data=%h busy=%b done=%b err=%b code=%0d count=%h, expected all 0",
                  tag, req_ready, mem_wr_en, mem_addr, mem_wdata, busy, done, err, err_code, word_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      req_t r;
      mem_ready = 1'b1;
      start_session(16'h0100);
      r = blank(4'd2); r.byt = 1; r.src = 3; r.dst = 5;
      send(r, 1, 16'h405D);
      check_out("alu", 16'h0100, 16'h405D);
      r = blank(4'd9); r.kind = 2'b11; r.imm = 8'hAB; r.dst = 2;
      send(r, 1, 16'h7D5A);
      check_out("movh", 16'h0102, 16'h7D5A);
      r = blank(4'd1); r.cond = 1; r.offset = 16'hFFFC; r.last = 1;
      send(r, 1, 16'h27FE);
      check_out("brc", 16'h0104, 16'h27FE);
      wait_done("basic");
      check_end("basic", 16'd3, 1'b0, 2'd0);
   endtask

   task automatic test_errors();
      req_t r;
      mem_ready = 1'b1;
      start_session(16'h0300);
      r = blank(4'd0); r.offset = 16'd8190;
      send(r, 1, 16'h0FFF);
      r = blank(4'd0); r.offset = 16'd8192;
      send(r, 0, 16'h0000);
      check_end("bl_range", 16'd1, 1'b1, 2'd1);
      r = blank(4'd1); r.offset = 16'd3;
      send(r, 0, 16'h0000);
      check_end("err_sticky", 16'd1, 1'b1, 2'd1);
      r = blank(4'd10); r.offset = 16'hFFC0; r.src = 1; r.dst = 2;
      send(r, 1, 16'hA00A);
      r = blank(4'd11); r.offset = 16'd64;
      send(r, 0, 16'h0000);
      r = blank(4'd3); r.func = 4'd1; r.rc = 1; r.src = 7; r.dst = 0;
      send(r, 1, 16'h4EB8);
      r = blank(4'd4); r.rc = 1; r.src = 2; r.dst = 4;
      send(r, 1, 16'h4C94);
      r = blank(4'd5); r.addr_mode = 3'b100; r.byt = 1; r.src = 6; r.dst = 1;
      send(r, 1, 16'h5271);
      r = blank(4'd6); r.addr_mode = 3'b010; r.src = 0; r.dst = 7;
      send(r, 1, 16'h5507);
      r = blank(4'd7); r.payload = 10'h155;
      send(r, 1, 16'h5955);
      r = blank(4'd8); r.payload = 10'h3FF;
      send(r, 1, 16'h5FFF);
      r = blank(4'd11); r.offset = 16'd63; r.byt = 1; r.src = 5; r.dst = 3;
      send(r, 1, 16'hDFEB);
      r = blank(4'd1); r.cond = 7; r.offset = 16'd1022;
      send(r, 1, 16'h3DFF);
      r = blank(4'd9); r.kind = 2'b01; r.imm = 8'h00; r.dst = 7; r.last = 1;
      send(r, 1, 16'h6807);
      wait_done("errors");
      check_end("errors", 16'd11, 1'b1, 2'd1);
   endtask

   task automatic test_priority();
      req_t       r;
      req_t       cases[4];
      logic [1:0] codes[4];
      mem_ready = 1'b1;
      cases[0] = blank(4'd13); cases[0].offset = 16'd3;     codes[0] = 2'd0;
      cases[1] = blank(4'd0);  cases[1].offset = 16'd8193;  codes[1] = 2'd2;
      cases[2] = blank(4'd2);  cases[2].func = 4'b1100;     codes[2] = 2'd0;
      cases[3] = blank(4'd1);  cases[3].offset = 16'hFBFE;  codes[3] = 2'd1;
      for (int i = 0; i < 4; i++) begin
         start_session(16'h0700);
         r = cases[i];
         r.last = 1;
         send(r, 0, 16'h0000);
         wait_done("priority");
         check_end("priority", 16'd0, 1'b1, codes[i]);
      end
   endtask

   task automatic test_backpressure();
      req_t r;
      start_session(16'h0400);
      mem_ready = 1'b0;
      fork
         begin
            r = blank(4'd2); r.func = 4'd3; r.src = 1; r.dst = 1;
            send(r, 1, 16'h4309);
            r = blank(4'd9); r.imm = 8'h12; r.dst = 4;
            send(r, 1, 16'h6094);
            r = blank(4'd10); r.offset = 16'd2; r.src = 3; r.dst = 3; r.last = 1;
            send(r, 1, 16'h811B);
         end
         begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (mem_wr_en) begin
                  seen = 1;
                  break;
               end
            end
            total++;
            if (!seen) begin
               bad++;
               $display("FAIL stall_wr_en: got mem_wr_en=0 for 20 cycles, expected 1");
            end
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               total++;
               if ({req_ready, mem_wr_en, mem_addr, mem_wdata} !== {2'b01, 16'h0400, 16'h4309}) begin
                  bad++;
                  $display("FAIL stall_hold: got rdy=%b wr=%b addr=%h data=%h, expected 0 1 0400 4309",
                           req_ready, mem_wr_en, mem_addr, mem_wdata);
               end
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b1;
         end
      join
      wait_done("stall");
      check_end("stall", 16'd3, 1'b0, 2'd0);
   endtask

   task automatic test_back_to_back();
      req_t r;
      mem_ready = 1'b1;
      start_session(16'hFFFC);
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               r = blank(4'd9); r.imm = 8'(i); r.dst = 3'(i); r.last = (i == 3);
               send(r, 1, {5'b01100, 8'(i), 3'(i)});
            end
         end
         begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (mem_wr_en) begin
                  seen = 1;
                  break;
               end
            end
            for (int k = 1; k < 4; k++) begin
               @(negedge clk);
               total++;
               if (!seen || !(mem_wr_en && mem_ready)) begin
                  bad++;
                  $display("FAIL back_to_back: got write=%b in slot %0d, expected 1", mem_wr_en && mem_ready, k);
               end
            end
         end
      join
      wait_done("b2b");
      check_end("b2b", 16'd4, 1'b0, 2'd0);
      total++;
      if (mem_addr !== 16'h0004) begin
         bad++;
         $display("FAIL ptr_wrap: got addr=%h, expected 0004", mem_addr);
      end
   endtask

   task automatic test_reset_mid();
      req_t r;
      mem_ready = 1'b0;
      start_session(16'h0500);
      r = blank(4'd2); r.src = 2; r.dst = 2;
      send(r, 1, 16'h4012);
      check_out("pending", 16'h0500, 16'h4012);
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      start_session(16'h0200);
      r = blank(4'd9); r.kind = 2'b10; r.imm = 8'h80; r.dst = 6; r.last = 1;
      send(r, 1, 16'h7406);
      wait_done("after_reset");
      check_end("after_reset", 16'd1, 1'b0, 2'd0);
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_ptr = '0;
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      req_valid = 1'b0;
      req_class = '0;
      req_func = '0;
      req_rc = 1'b0;
      req_byte = 1'b0;
      req_src = '0;
      req_dst = '0;
      req_cond = '0;
      req_offset = '0;
      req_addr_mode = '0;
      req_mov_kind = '0;
      req_imm = '0;
      req_payload = '0;
      req_last = 1'b0;
      mem_ready = 1'b1;

      test_reset();
      test_basic();
      test_errors();
      test_priority();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_empty: got %0d pending words, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
